// File: rtl/snax_alu_job_ctrl.sv
// Job sequencer in front of the SNAX ALU PE array: latches a job from the CSRs,
// admits exactly `len` operand beats, counts results and reports status/cycles.
module snax_alu_job_ctrl #(
  parameter int unsigned RegRWCount   = 3,
  parameter int unsigned RegROCount   = 2,
  parameter int unsigned RegDataWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [RegDataWidth-1:0] csr_reg_set_i [RegRWCount],
  input  logic                    csr_reg_set_valid_i,
  output logic                    csr_reg_set_ready_o,
  output logic [RegDataWidth-1:0] csr_reg_ro_set_o [RegROCount],
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic                    pe_valid_o,
  input  logic                    pe_ready_i,
  input  logic                    out_valid_i,
  input  logic                    out_ready_i,
  output logic [1:0]              alu_config_o
);

  localparam logic [RegDataWidth-1:0] CntOne = RegDataWidth'(1);

  typedef enum logic [1:0] {
    Idle  = 2'd0,
    Run   = 2'd1,
    Drain = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              mode_q, mode_d;
  logic [RegDataWidth-1:0] len_q, len_d;
  logic [RegDataWidth-1:0] in_cnt_q, in_cnt_d;
  logic [RegDataWidth-1:0] out_cnt_q, out_cnt_d;
  logic [RegDataWidth-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [15:0]             job_cnt_q, job_cnt_d;
  logic                    done_q, done_d;

  logic gate, in_fire, out_fire, csr_fire, busy;
  logic [RegDataWidth-1:0] status;

  // The operand path is purely combinational so a beat can fire the cycle after start.
  assign busy                = (state_q != Idle);
  assign gate                = (state_q == Run) && (in_cnt_q < len_q);
  assign in_ready_o          = gate && pe_ready_i;
  assign pe_valid_o          = gate && in_valid_i;
  assign in_fire             = in_valid_i && in_ready_o;
  assign out_fire            = busy && out_valid_i && out_ready_i;
  assign csr_reg_set_ready_o = (state_q == Idle);
  assign csr_fire            = csr_reg_set_valid_i && csr_reg_set_ready_o;
  assign alu_config_o        = mode_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    mode_d    = mode_q;
    len_d     = len_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    job_cnt_d = job_cnt_q;
    done_d    = done_q;

    unique case (state_q)
      Idle: begin
        if (csr_fire) begin
          mode_d = csr_reg_set_i[0][1:0];
          len_d  = csr_reg_set_i[1];
          if (csr_reg_set_i[2][0]) begin
            cyc_cnt_d = '0;
            if (csr_reg_set_i[1] != '0) begin
              in_cnt_d  = '0;
              out_cnt_d = '0;
              done_d    = 1'b0;
              state_d   = Run;
            end else begin
              // An empty job completes on the spot without leaving Idle.
              done_d    = 1'b1;
              job_cnt_d = job_cnt_q + 16'd1;
            end
          end
        end
      end
      Run, Drain: begin
        if (cyc_cnt_q != '1) cyc_cnt_d = cyc_cnt_q + CntOne;
        if (in_fire) begin
          in_cnt_d = in_cnt_q + CntOne;
          if (in_cnt_d == len_q) state_d = Drain;
        end
        // Completion wins over the Run->Drain move when last-in and last-out coincide.
        if (out_fire) begin
          out_cnt_d = out_cnt_q + CntOne;
          if (out_cnt_d == len_q) begin
            state_d   = Idle;
            done_d    = 1'b1;
            job_cnt_d = job_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = Idle;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= Idle;
      mode_q    <= '0;
      len_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      cyc_cnt_q <= '0;
      job_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      len_q     <= len_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
      job_cnt_q <= job_cnt_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    status                         = '0;
    status[0]                      = busy;
    status[1]                      = done_q;
    status[RegDataWidth-1 -: 16]   = job_cnt_q;
    for (int i = 0; i < int'(RegROCount); i++) csr_reg_ro_set_o[i] = '0;
    csr_reg_ro_set_o[0] = status;
    csr_reg_ro_set_o[1] = cyc_cnt_q;
  end

  logic unused_csr_bits;
  assign unused_csr_bits = ^{csr_reg_set_i[0][RegDataWidth-1:2], csr_reg_set_i[2][RegDataWidth-1:1]};

endmodule
